// File: rtl/vreg_arbiter_if.sv
// Bus between the vector execution units, the register-file arbiter and the
// single-port vector register file. The arbiter sees the slave view.
interface vreg_arbiter_if #(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned DATA_W = 256,
   parameter int unsigned ADDR_W = 3
);
   // requester side
   logic [NREQ-1:0]        Req;
   logic [NREQ-1:0]        ReqWr;
   logic [NREQ*ADDR_W-1:0] ReqAddr;
   logic [NREQ*DATA_W-1:0] ReqData;
   logic [NREQ-1:0]        Gnt;
   logic                   RdValid;
   logic [NREQ-1:0]        RdId;
   logic [DATA_W-1:0]      RdData;
   logic                   Busy;
   // register file side
   logic [ADDR_W-1:0]      Addr;
   logic [DATA_W-1:0]      DataIn;
   logic                   RD_p;
   logic                   WR_p;
   logic [DATA_W-1:0]      DataOut;

   modport slave (
      input  Req, ReqWr, ReqAddr, ReqData, DataOut,
      output Gnt, RdValid, RdId, RdData, Busy, Addr, DataIn, RD_p, WR_p
   );

   modport master (
      output Req, ReqWr, ReqAddr, ReqData, DataOut,
      input  Gnt, RdValid, RdId, RdData, Busy, Addr, DataIn, RD_p, WR_p
   );
endinterface

// File: rtl/vreg_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port vector register file
// between NREQ requesters. One operation at a time; read data returns with a
// one-cycle valid pulse tagged with the one-hot owner.
module vreg_arbiter #(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned DATA_W = 256,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned RD_LAT = 2
) (
   input logic           Clk,
   input logic           Rst_n,
   vreg_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = (NREQ > 1)   ? $clog2(NREQ)   : 1;
   localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

   state_t            state_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [NREQ-1:0]   owner_q;
   logic [NREQ-1:0]   gnt_q;
   logic [NREQ-1:0]   rdid_q;
   logic              rdvalid_q;
   logic              busy_q;
   logic              rd_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic [DATA_W-1:0] rddata_q;

   logic [ADDR_W-1:0] req_addr [NREQ];
   logic [DATA_W-1:0] req_data [NREQ];

   logic              win_found;
   logic [PTR_W-1:0]  win_idx;
   logic [PTR_W-1:0]  cand;
   logic [PTR_W-1:0]  ptr_d;
   logic [NREQ-1:0]   win_oh;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_addr[g] = bus.ReqAddr[g*ADDR_W +: ADDR_W];
      assign req_data[g] = bus.ReqData[g*DATA_W +: DATA_W];
   end

   // Winner = first requester set, searching from the round-robin pointer upward
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand = PTR_W'((32'(ptr_q) + off) % NREQ);
         if (!win_found && bus.Req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      win_oh = NREQ'(1) << win_idx;
      ptr_d  = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
   end

   // Sequencer: grant in IDLE, then drive one write or one read to the register file
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         owner_q   <= '0;
         gnt_q     <= '0;
         rdid_q    <= '0;
         rdvalid_q <= 1'b0;
         busy_q    <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         rddata_q  <= '0;
      end else begin
         gnt_q     <= '0;
         rdvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  gnt_q   <= win_oh;
                  owner_q <= win_oh;
                  addr_q  <= req_addr[win_idx];
                  din_q   <= req_data[win_idx];
                  ptr_q   <= ptr_d;
                  busy_q  <= 1'b1;
                  if (bus.ReqWr[win_idx]) begin
                     wr_q    <= 1'b1;
                     state_q <= WRITE;
                  end else begin
                     rd_q    <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= READ;
                  end
               end
            end
            WRITE: begin
               wr_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            READ: begin
               state_q <= RWAIT;
            end
            RWAIT: begin
               if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                  rddata_q  <= bus.DataOut;
                  rdid_q    <= owner_q;
                  rdvalid_q <= 1'b1;
                  rd_q      <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Gnt     = gnt_q;
   assign bus.RdValid = rdvalid_q;
   assign bus.RdId    = rdid_q;
   assign bus.RdData  = rddata_q;
   assign bus.Busy    = busy_q;
   assign bus.Addr    = addr_q;
   assign bus.DataIn  = din_q;
   assign bus.RD_p    = rd_q;
   assign bus.WR_p    = wr_q;

endmodule
